regfile_sb: RTL



---
 rtl/rf_pkg.sv | 20 ++
 rtl/regfile_sb_if.sv | 39 +++
 rtl/regfile_sb_scoreboard.sv | 58 +++++
 rtl/regfile_sb.sv | 64 ++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file defaults for decode, issue and writeback
//
// Purpose: default width/depth/stack-pointer constants for the integer
//          register file, plus a small address helper.
// Ports:   none (package).
package rf_pkg;

   localparam int          XLEN_D     = 32;
   localparam int          NREGS_D    = 32;
   localparam int          AW_D       = $clog2(NREGS_D);
   localparam int          NRD_D      = 2;
   localparam int          SP_IDX_D   = 2;
   localparam logic [31:0] SP_RESET_D = 32'h0000_8000;

   // Register 0 is hardwired: it is never written and never reserved.
   function automatic logic is_nz(input logic [AW_D-1:0] a);
      return a != '0;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/issue/writeback bundle of the scoreboarded register file
//
// Purpose: groups the read ports, issue reservation and writeback strobe.
// Ports:   master = decode/issue/writeback side, slave = register file.
//          rd_addr/rd_data/rd_ready : NRD packed read ports
//          iss_valid/iss_addr/iss_stall : destination reservation
//          wb_valid/wb_addr/wb_data : result return
//          busy_cnt, wb_err : status
import rf_pkg::*;

interface regfile_sb_if #(
   parameter int XLEN  = XLEN_D,
   parameter int NREGS = NREGS_D,
   parameter int NRD   = NRD_D
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_ready;
   logic                iss_valid;
   logic [AW-1:0]       iss_addr;
   logic                iss_stall;
   logic                wb_valid;
   logic [AW-1:0]       wb_addr;
   logic [XLEN-1:0]     wb_data;
   logic [AW:0]         busy_cnt;
   logic                wb_err;

   modport master (
      output rd_addr, iss_valid, iss_addr, wb_valid, wb_addr, wb_data,
      input  rd_data, rd_ready, iss_stall, busy_cnt, wb_err
   );

   modport slave (
      input  rd_addr, iss_valid, iss_addr, wb_valid, wb_addr, wb_data,
      output rd_data, rd_ready, iss_stall, busy_cnt, wb_err
   );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// rtl/regfile_sb_scoreboard.sv - per-register busy tracking with issue stall
//
// Purpose: holds the busy vector, refuses reservations of busy registers,
//          counts busy registers and flags writebacks to idle registers.
// Ports:   clk, reset_n (async active-low)
//          iss_valid/iss_addr in, iss_stall out (combinational)
//          wb_valid/wb_addr in
//          busy out (NREGS, bit 0 always 0), busy_cnt out, wb_err out (sticky)
import rf_pkg::*;

module regfile_sb_scoreboard #(
   parameter int NREGS = NREGS_D,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             iss_valid,
   input  logic [AW-1:0]    iss_addr,
   input  logic             wb_valid,
   input  logic [AW-1:0]    wb_addr,
   output logic             iss_stall,
   output logic [NREGS-1:0] busy,
   output logic [AW:0]      busy_cnt,
   output logic             wb_err
);
   logic             iss_hit, wb_hit, iss_acc, wb_clr;
   logic [NREGS-1:0] busy_nxt;

   assign iss_hit = iss_valid && (iss_addr != '0);
   assign wb_hit  = wb_valid && (wb_addr != '0);

   // A writeback releasing the same register this cycle lets the issue through.
   assign iss_stall = iss_hit && busy[iss_addr] && !(wb_valid && (wb_addr == iss_addr));
   assign iss_acc   = iss_hit && !iss_stall;
   assign wb_clr    = wb_hit && busy[wb_addr];

   // Issue is applied after writeback so a same-register collision stays busy.
   always_comb begin
      busy_nxt = busy;
      if (wb_hit)  busy_nxt[wb_addr]  = 1'b0;
      if (iss_acc) busy_nxt[iss_addr] = 1'b1;
   end

   // An accepted issue always ends with a newly set bit (either it was idle,
   // or the colliding writeback just cleared it), so it always counts +1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy     <= '0;
         busy_cnt <= '0;
         wb_err   <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= busy_cnt + (AW+1)'(iss_acc) - (AW+1)'(wb_clr);
         if (wb_hit && !busy[wb_addr])
            wb_err <= 1'b1;
      end
   end
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port integer register file with busy scoreboard
//
// Purpose: data array and read muxes; busy tracking lives in
//          regfile_sb_scoreboard.
// Ports:   clk, reset_n (async active-low), bus (regfile_sb_if.slave).
// Config:  RF_BYPASS_EN - when defined, a same-cycle writeback to a read
//          address is forwarded to that read port and marks it ready.
import rf_pkg::*;

module regfile_sb #(
   parameter int              XLEN     = XLEN_D,
   parameter int              NREGS    = NREGS_D,
   parameter int              NRD      = NRD_D,
   parameter int              SP_IDX   = SP_IDX_D,
   parameter logic [XLEN-1:0] SP_RESET = XLEN'(SP_RESET_D)
) (
   input  logic        clk,
   input  logic        reset_n,
   regfile_sb_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic             wb_hit;

   assign wb_hit = bus.wb_valid && (bus.wb_addr != '0);

   regfile_sb_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
      .clk       (clk),
      .reset_n   (reset_n),
      .iss_valid (bus.iss_valid),
      .iss_addr  (bus.iss_addr),
      .wb_valid  (bus.wb_valid),
      .wb_addr   (bus.wb_addr),
      .iss_stall (bus.iss_stall),
      .busy      (busy),
      .busy_cnt  (bus.busy_cnt),
      .wb_err    (bus.wb_err)
   );

   // regs[0] is only ever loaded by reset with 0, so it always reads 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++)
            regs[r] <= (r == SP_IDX) ? SP_RESET : '0;
      end else if (wb_hit) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          byp;
      assign a = bus.rd_addr[i*AW +: AW];
`ifdef RF_BYPASS_EN
      assign byp = wb_hit && (bus.wb_addr == a);
`else
      assign byp = 1'b0;
`endif
      assign bus.rd_data[i*XLEN +: XLEN] = byp ? bus.wb_data : regs[a];
      assign bus.rd_ready[i] = (a == '0) || !busy[a] || byp;
   end
endmodule
